pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed fetch/decode stage register.
- Two-entry skid-buffered pipeline stage with a valid/ready handshake on both sides.
- Supports flush and an interrupt-request override.
- Carries a PC field plus a generic payload, so one module serves every stage boundary (F/D, D/E, E/M, M/W) in the P7 pipeline.

Parameters:
- PC_W, 32, PC field width.
- PAYLOAD_W, 38, width of the rest of the stage bundle (instr + exc_code + branch_delay by default).
- PC_RST, 32'h0000_3000, PC value of a bubble.
- PC_INT, 32'h0000_4180, PC injected on interrupt request.
- PAYLOAD_RST, {PAYLOAD_W{1'b0}}, payload value of a bubble (nop, no exception, no delay slot).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  discard all held entries.
- i_req  in  1  interrupt request; overrides flush.
- i_valid  in  1  upstream entry valid.
- o_ready  out  1  stage can accept an entry this cycle.
- i_pc  in  PC_W  upstream PC.
- i_payload  in  PAYLOAD_W  upstream bundle.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts the output entry.
- o_pc  out  PC_W  output PC.
- o_payload  out  PAYLOAD_W  output bundle.
- o_count  out  2  occupancy, 0..2.

Behaviour:
- Storage: main entry (drives o_*) and skid entry. Each entry is {valid, pc, payload}.
- Main always holds the oldest entry.
- State is derived from occupancy: EMPTY (0), ONE (main only), FULL (main + skid).
- o_ready = (state != FULL). It is a registered, state-derived signal and has no combinational path from i_ready.
- Handshakes: acc_in = i_valid && o_ready; acc_out = o_valid && i_ready.
- Payload and PC are sampled only on acc_in. The output bundle must hold stable while o_valid && !i_ready.
- Reset (i_reset_n low, asynchronous assertion) clears everything:
  - o_valid=0, o_pc=PC_RST, o_payload=PAYLOAD_RST, o_count=0, o_ready=1.
  - Skid entry is cleared to the same bubble values.
  - Deassertion is sampled on the next rising edge.
- Transitions (no flush/req):
  - EMPTY, acc_in -> main<=input, go to ONE.
  - ONE, acc_in && acc_out -> main<=input, stay in ONE (full throughput, zero added bubbles).
  - ONE, acc_in only -> skid<=input, go to FULL.
  - ONE, acc_out only -> main<=bubble, go to EMPTY.
  - FULL, acc_out -> main<=skid, skid<=bubble, go to ONE. No acc_in is possible in FULL.
  - Otherwise hold.
- Latency: 1 cycle from acc_in to o_valid when the stage was EMPTY, or ONE with acc_out.
- Flush (i_flush=1, i_req=0):
  - Next edge: both entries become bubbles, o_valid=0, o_pc=PC_RST, state EMPTY.
  - A concurrent acc_in entry is dropped.
  - A concurrent acc_out still counts as delivered downstream.
- Request (i_req=1), highest priority after reset:
  - Next edge: main<={1, PC_INT, PAYLOAD_RST}, skid<=bubble, state ONE.
  - Input is dropped. This applies regardless of i_flush.
- Boundaries:
  - Bubble entries (valid=0) never assert o_valid.
  - o_count is always consistent with state.
  - An asynchronous reset mid-transfer discards both entries immediately; no partial update is permitted.
  - Values of i_pc/i_payload are don't-care when i_valid=0.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- With the macro defined:
  - Adds output o_stall_cnt [31:0], reset 0.
  - Increments (wrapping at 2^32) on every cycle with o_valid && !i_ready.
  - Adds output o_full_cnt [31:0], reset 0, incrementing on every cycle with state FULL.
  - Flush and req do not clear either counter; only reset does.
- Without the macro: neither port exists, and the datapath is identical.

Test Plan:
- Reset then idle: o_valid=0, o_pc=32'h3000, o_payload=0, o_count=0, o_ready=1.
- Streaming with i_ready=1, i_pc=0x3000,0x3004,0x3008 back-to-back: o_pc shows the same sequence one cycle later, o_ready stays 1, o_count stays 1.
- Backpressure: i_ready=0, push 0x3000 and 0x3004. o_count=2, o_ready=0 on the following cycle, o_pc holds 0x3000. Raise i_ready: outputs 0x3000 then 0x3004, no loss or duplication.
- Flush while FULL with i_valid=1 (pc 0x3008): next cycle o_valid=0, o_pc=0x3000, o_count=0, and 0x3008 is never output.
- i_req and i_flush together while ONE: next cycle o_valid=1, o_pc=0x4180, o_payload=0, o_count=1.
- Asynchronous reset pulse mid-cycle while FULL: outputs clear before the next edge. With PIPE_STAGE_PERF_EN, 5 stalled cycles then reset give o_stall_cnt 5 -> 0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid-buffered pipeline stage with flush and interrupt override
//
// Purpose:
//   Generic stage register for every boundary of the P7 pipeline (F/D, D/E, E/M, M/W).
//   Holds up to two entries: the main entry drives the outputs and always holds the
//   oldest entry; the skid entry catches the one extra entry that can arrive in the
//   cycle after downstream stalls. o_ready is derived only from registered state, so
//   there is no combinational path from i_ready to o_ready.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_flush      discard all held entries (and any concurrent input)
//   i_req        interrupt request; loads an entry at PC_INT, overrides i_flush
//   i_valid      upstream entry valid
//   o_ready      stage can accept an entry this cycle
//   i_pc         upstream PC
//   i_payload    upstream bundle
//   o_valid      output entry valid
//   i_ready      downstream accepts the output entry
//   o_pc         output PC
//   o_payload    output bundle
//   o_stall_cnt  cycles with o_valid && !i_ready (only with PIPE_STAGE_PERF_EN)
//   o_full_cnt   cycles spent in FULL (only with PIPE_STAGE_PERF_EN)
//   o_count      occupancy, 0..2
//
// Optional feature macro: PIPE_STAGE_PERF_EN (adds the two performance counters).

module pipe_stage_skid #(
    parameter int                     PC_W        = 32,
    parameter int                     PAYLOAD_W   = 38,
    parameter logic [PC_W-1:0]        PC_RST      = 32'h0000_3000,
    parameter logic [PC_W-1:0]        PC_INT      = 32'h0000_4180,
    parameter logic [PAYLOAD_W-1:0]   PAYLOAD_RST = {PAYLOAD_W{1'b0}}
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_flush,
    input  logic                  i_req,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [PC_W-1:0]       i_pc,
    input  logic [PAYLOAD_W-1:0]  i_payload,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [PC_W-1:0]       o_pc,
    output logic [PAYLOAD_W-1:0]  o_payload,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]           o_stall_cnt,
    output logic [31:0]           o_full_cnt,
`endif
    output logic [1:0]            o_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                 state_q,        state_d;
    logic                   main_valid_q,   main_valid_d;
    logic [PC_W-1:0]        main_pc_q,      main_pc_d;
    logic [PAYLOAD_W-1:0]   main_payload_q, main_payload_d;
    logic                   skid_valid_q,   skid_valid_d;
    logic [PC_W-1:0]        skid_pc_q,      skid_pc_d;
    logic [PAYLOAD_W-1:0]   skid_payload_q, skid_payload_d;

    logic acc_in;
    logic acc_out;

    // Ready depends only on the registered state: accept unless both entries are used.
    assign o_ready   = (state_q != ST_FULL);
    assign o_valid   = main_valid_q;
    assign o_pc      = main_pc_q;
    assign o_payload = main_payload_q;

    assign acc_in  = i_valid && o_ready;
    assign acc_out = main_valid_q && i_ready;

    always_comb begin
        o_count = 2'd0;
        case (state_q)
            ST_EMPTY: o_count = 2'd0;
            ST_ONE:   o_count = 2'd1;
            ST_FULL:  o_count = 2'd2;
            default:  o_count = 2'd0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        main_valid_d   = main_valid_q;
        main_pc_d      = main_pc_q;
        main_payload_d = main_payload_q;
        skid_valid_d   = skid_valid_q;
        skid_pc_d      = skid_pc_q;
        skid_payload_d = skid_payload_q;

        if (i_req) begin
            // Interrupt entry replaces everything; input is dropped even if accepted.
            state_d        = ST_ONE;
            main_valid_d   = 1'b1;
            main_pc_d      = PC_INT;
            main_payload_d = PAYLOAD_RST;
            skid_valid_d   = 1'b0;
            skid_pc_d      = PC_RST;
            skid_payload_d = PAYLOAD_RST;
        end else if (i_flush) begin
            // A concurrent acc_out has already been seen downstream; nothing to undo.
            state_d        = ST_EMPTY;
            main_valid_d   = 1'b0;
            main_pc_d      = PC_RST;
            main_payload_d = PAYLOAD_RST;
            skid_valid_d   = 1'b0;
            skid_pc_d      = PC_RST;
            skid_payload_d = PAYLOAD_RST;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_in) begin
                        state_d        = ST_ONE;
                        main_valid_d   = 1'b1;
                        main_pc_d      = i_pc;
                        main_payload_d = i_payload;
                    end
                end
                ST_ONE: begin
                    if (acc_in && acc_out) begin
                        // Pass-through at full throughput: main is replaced in place.
                        main_valid_d   = 1'b1;
                        main_pc_d      = i_pc;
                        main_payload_d = i_payload;
                    end else if (acc_in) begin
                        // Downstream stalled: park the newer entry in skid.
                        state_d        = ST_FULL;
                        skid_valid_d   = 1'b1;
                        skid_pc_d      = i_pc;
                        skid_payload_d = i_payload;
                    end else if (acc_out) begin
                        state_d        = ST_EMPTY;
                        main_valid_d   = 1'b0;
                        main_pc_d      = PC_RST;
                        main_payload_d = PAYLOAD_RST;
                    end
                end
                ST_FULL: begin
                    // o_ready is low here, so only the drain case exists.
                    if (acc_out) begin
                        state_d        = ST_ONE;
                        main_valid_d   = skid_valid_q;
                        main_pc_d      = skid_pc_q;
                        main_payload_d = skid_payload_q;
                        skid_valid_d   = 1'b0;
                        skid_pc_d      = PC_RST;
                        skid_payload_d = PAYLOAD_RST;
                    end
                end
                default: begin
                    state_d        = ST_EMPTY;
                    main_valid_d   = 1'b0;
                    main_pc_d      = PC_RST;
                    main_payload_d = PAYLOAD_RST;
                    skid_valid_d   = 1'b0;
                    skid_pc_d      = PC_RST;
                    skid_payload_d = PAYLOAD_RST;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= ST_EMPTY;
            main_valid_q   <= 1'b0;
            main_pc_q      <= PC_RST;
            main_payload_q <= PAYLOAD_RST;
            skid_valid_q   <= 1'b0;
            skid_pc_q      <= PC_RST;
            skid_payload_q <= PAYLOAD_RST;
        end else begin
            state_q        <= state_d;
            main_valid_q   <= main_valid_d;
            main_pc_q      <= main_pc_d;
            main_payload_q <= main_payload_d;
            skid_valid_q   <= skid_valid_d;
            skid_pc_q      <= skid_pc_d;
            skid_payload_q <= skid_payload_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] full_cnt_q,  full_cnt_d;

    // Counters survive flush and req; only reset clears them. Both wrap naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        full_cnt_d  = full_cnt_q;
        if (main_valid_q && !i_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (state_q == ST_FULL) begin
            full_cnt_d = full_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cnt_q <= 32'd0;
            full_cnt_q  <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            full_cnt_q  <= full_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_full_cnt  = full_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid with a queue reference model

module tb_pipe_stage_skid;

    localparam int               PC_W        = 32;
    localparam int               PAYLOAD_W   = 38;
    localparam logic [PC_W-1:0]  PC_RST      = 32'h0000_3000;
    localparam logic [PC_W-1:0]  PC_INT      = 32'h0000_4180;
    localparam logic [PAYLOAD_W-1:0] PAYLOAD_RST = '0;
    localparam int               VW          = 1 + PC_W + PAYLOAD_W + 2 + 1;

    logic                  i_clk;
    logic                  i_reset_n;
    logic                  i_flush;
    logic                  i_req;
    logic                  i_valid;
    logic                  o_ready;
    logic [PC_W-1:0]       i_pc;
    logic [PAYLOAD_W-1:0]  i_payload;
    logic                  o_valid;
    logic                  i_ready;
    logic [PC_W-1:0]       o_pc;
    logic [PAYLOAD_W-1:0]  o_payload;
    logic [1:0]            o_count;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]           o_stall_cnt;
    logic [31:0]           o_full_cnt;
`endif

    pipe_stage_skid dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_flush     (i_flush),
        .i_req       (i_req),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_pc        (i_pc),
        .i_payload   (i_payload),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_pc        (o_pc),
        .o_payload   (o_payload),
`ifdef PIPE_STAGE_PERF_EN
        .o_stall_cnt (o_stall_cnt),
        .o_full_cnt  (o_full_cnt),
`endif
        .o_count     (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO of held entries, at most two; front is what the stage shows.
    logic [PC_W+PAYLOAD_W-1:0] mq[$];
    longint unsigned stall_m = 0;
    longint unsigned full_m  = 0;

    wire [VW-1:0] dut_vec = {o_valid, o_pc, o_payload, o_count, o_ready};

    function automatic logic [VW-1:0] exp_vec();
        if (mq.size() == 0)
            return {1'b0, PC_RST, PAYLOAD_RST, 2'd0, 1'b1};
        return {1'b1, mq[0], 2'(mq.size()), (mq.size() < 2)};
    endfunction

    task automatic idle_inputs();
        i_flush = 1'b0; i_req = 1'b0; i_valid = 1'b0;
        i_pc = '0; i_payload = '0;
    endtask

    // Advance one clock: update the model from the inputs seen at this edge, then sample #1 later.
    task automatic cycle();
        int sz;
        bit a_in, a_out;
        sz    = mq.size();
        a_out = (sz > 0) && i_ready;
        a_in  = i_valid && (sz < 2);
        if (sz > 0 && !i_ready) stall_m++;
        if (sz == 2) full_m++;
        if (i_req) begin
            mq.delete();
            mq.push_back({PC_INT, PAYLOAD_RST});
        end else if (i_flush) begin
            mq.delete();
        end else begin
            if (a_out) void'(mq.pop_front());
            if (a_in) mq.push_back({i_pc, i_payload});
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic [PAYLOAD_W-1:0] pl);
        i_valid = 1'b1; i_pc = pc; i_payload = pl;
        cycle();
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_ready = 1'b0;
        i_reset_n = 1'b0;
        mq.delete(); stall_m = 0; full_m = 0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #3;
        i_reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (dut_vec !== {1'b0, 32'h0000_3000, 38'd0, 2'd0, 1'b1}) begin
                bad++;
                $display("FAIL reset_idle got=%h exp=%h", dut_vec, {1'b0, 32'h0000_3000, 38'd0, 2'd0, 1'b1});
            end
        end
    endtask

    task automatic test_stream();
        logic [PC_W-1:0] pcs[3];
        pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
        do_reset();
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(pcs[i], PAYLOAD_W'(i + 1));
            total++;
            if (o_pc !== pcs[i] || o_valid !== 1'b1 || o_count !== 2'd1 || o_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_%0d got pc=%h v=%b cnt=%0d rdy=%b exp pc=%h v=1 cnt=1 rdy=1",
                         i, o_pc, o_valid, o_count, o_ready, pcs[i]);
            end
        end
        cycle();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL stream_drain got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_ready = 1'b0;
        push(32'h3000, 38'h11);
        push(32'h3004, 38'h22);
        total++;
        if (o_count !== 2'd2 || o_ready !== 1'b0 || o_pc !== 32'h3000 || o_payload !== 38'h11) begin
            bad++;
            $display("FAIL bp_full got cnt=%0d rdy=%b pc=%h exp cnt=2 rdy=0 pc=3000", o_count, o_ready, o_pc);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (o_pc !== 32'h3000 || o_count !== 2'd2) begin
                bad++;
                $display("FAIL bp_hold got pc=%h cnt=%0d exp pc=3000 cnt=2", o_pc, o_count);
            end
        end
        i_ready = 1'b1;
        cycle();
        total++;
        if (o_valid !== 1'b1 || o_pc !== 32'h3004 || o_payload !== 38'h22 || o_count !== 2'd1) begin
            bad++;
            $display("FAIL bp_second got v=%b pc=%h cnt=%0d exp v=1 pc=3004 cnt=1", o_valid, o_pc, o_count);
        end
        cycle();
        total++;
        if (dut_vec !== {1'b0, PC_RST, PAYLOAD_RST, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL bp_empty got=%h exp=%h", dut_vec, {1'b0, PC_RST, PAYLOAD_RST, 2'd0, 1'b1});
        end
    endtask

    task automatic test_flush();
        do_reset();
        i_ready = 1'b0;
        push(32'h3000, 38'h1);
        push(32'h3004, 38'h2);
        i_valid = 1'b1; i_pc = 32'h3008; i_payload = 38'h3; i_flush = 1'b1;
        cycle();
        idle_inputs();
        total++;
        if (o_valid !== 1'b0 || o_pc !== 32'h3000 || o_count !== 2'd0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush got v=%b pc=%h cnt=%0d rdy=%b exp v=0 pc=3000 cnt=0 rdy=1",
                     o_valid, o_pc, o_count, o_ready);
        end
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (o_valid !== 1'b0 || o_pc === 32'h3008) begin
                bad++;
                $display("FAIL flush_drop got v=%b pc=%h exp v=0", o_valid, o_pc);
            end
        end
    endtask

    task automatic test_req();
        do_reset();
        i_ready = 1'b0;
        push(32'h3000, 38'h5);
        i_req = 1'b1; i_flush = 1'b1; i_valid = 1'b1; i_pc = 32'h3010; i_payload = 38'h7;
        cycle();
        idle_inputs();
        total++;
        if (o_valid !== 1'b1 || o_pc !== 32'h4180 || o_payload !== 38'd0 || o_count !== 2'd1) begin
            bad++;
            $display("FAIL req got v=%b pc=%h pl=%h cnt=%0d exp v=1 pc=4180 pl=0 cnt=1",
                     o_valid, o_pc, o_payload, o_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_ready = 1'b0;
        push(32'h3000, 38'h9);
        push(32'h3004, 38'ha);
        for (int i = 0; i < 4; i++) cycle();
        total++;
        if (o_count !== 2'd2) begin
            bad++;
            $display("FAIL areset_pre got cnt=%0d exp cnt=2", o_count);
        end
`ifdef PIPE_STAGE_PERF_EN
        total++;
        if (o_stall_cnt !== 32'd5 || o_full_cnt !== 32'd4) begin
            bad++;
            $display("FAIL perf_pre got stall=%0d full=%0d exp stall=5 full=4", o_stall_cnt, o_full_cnt);
        end
`endif
        #3;
        i_reset_n = 1'b0;
        #1;
        total++;
        if (dut_vec !== {1'b0, PC_RST, PAYLOAD_RST, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL areset_mid got=%h exp=%h", dut_vec, {1'b0, PC_RST, PAYLOAD_RST, 2'd0, 1'b1});
        end
`ifdef PIPE_STAGE_PERF_EN
        total++;
        if (o_stall_cnt !== 32'd0 || o_full_cnt !== 32'd0) begin
            bad++;
            $display("FAIL perf_reset got stall=%0d full=%0d exp 0 0", o_stall_cnt, o_full_cnt);
        end
`endif
        #1;
        i_reset_n = 1'b1;
        mq.delete(); stall_m = 0; full_m = 0;
        cycle();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL areset_after got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [63:0] r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom(), $urandom()};
            i_valid   = ($urandom_range(0, 3) != 0);
            i_ready   = ($urandom_range(0, 2) != 0);
            i_flush   = ($urandom_range(0, 19) == 0);
            i_req     = ($urandom_range(0, 39) == 0);
            i_pc      = $urandom();
            i_payload = r[PAYLOAD_W-1:0];
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random_%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
`ifdef PIPE_STAGE_PERF_EN
            total++;
            if (o_stall_cnt !== 32'(stall_m) || o_full_cnt !== 32'(full_m)) begin
                bad++;
                $display("FAIL random_perf_%0d got stall=%0d full=%0d exp stall=%0d full=%0d",
                         i, o_stall_cnt, o_full_cnt, stall_m, full_m);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        i_ready   = 1'b0;
        i_reset_n = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_req();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
